// File: rtl/cdc_pkg.sv
// Shared constants and the synchronizer-depth legality check for the toggle
// event crossing blocks.
package cdc_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PEND_W_DEF      = 2;
  localparam int CNT_W_DEF       = 8;

  function automatic bit sync_stages_legal(input int stages);
    return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Reset-to-0 multi-flop synchronizer for one asynchronous level; also used on
// the source side to bring the ack toggle back.
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out
);

  if (!sync_stages_legal(STAGES)) begin : g_bad_stages
    $error("cdc_sync_bit: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_toggle_rx.sv
// Receive side of the toggle event crossing: synchronize, decode transitions,
// buffer in a pending counter, deliver by valid/ready. ack_tog exists only
// when CDC_TOGGLE_RX_ACK_EN is defined.
module cdc_toggle_rx
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int PEND_W      = PEND_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
`ifdef CDC_TOGGLE_RX_ACK_EN
  output logic             ack_tog,
`endif
  input  logic             clr_ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

  logic              sync_s;
  logic              edge_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic              prev_q,      prev_d;
  logic [PEND_W-1:0] pend_q,      pend_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CNT_W-1:0]  evt_count_q, evt_count_d;
  logic              overflow_q,  overflow_d;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (tog_in),
    .q_out (sync_s)
  );

  // evt_valid is a flop, so pop never depends combinationally on evt_ready->evt_valid
  assign edge_s    = sync_s ^ prev_q;
  assign pop_s     = evt_valid_q & evt_ready;
  assign ovf_set_s = edge_s & ~pop_s & (pend_q == PEND_MAX);

  always_comb begin
    prev_d      = sync_s;
    pend_d      = pend_q;
    evt_count_d = evt_count_q;
    overflow_d  = overflow_q;
    if (edge_s && !pop_s) begin
      if (pend_q == PEND_MAX) begin
        pend_d = pend_q;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (pop_s && !edge_s) begin
      pend_d = pend_q - PEND_ONE;
    end else begin
      pend_d = pend_q;
    end
    if (pop_s) begin
      evt_count_d = evt_count_q + CNT_ONE;
    end else begin
      evt_count_d = evt_count_q;
    end
    // a fresh overflow beats a same-cycle clear so no drop goes unreported
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    evt_valid_d = (pend_d != PEND_ZERO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= 1'b0;
      pend_q      <= PEND_ZERO;
      evt_valid_q <= 1'b0;
      evt_count_q <= {CNT_W{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_count_q <= evt_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_count = evt_count_q;
  assign overflow  = overflow_q;

`ifdef CDC_TOGGLE_RX_ACK_EN
  logic ack_tog_q, ack_tog_d;

  always_comb begin
    if (pop_s) begin
      ack_tog_d = ~ack_tog_q;
    end else begin
      ack_tog_d = ack_tog_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_tog_q <= 1'b0;
    end else begin
      ack_tog_q <= ack_tog_d;
    end
  end

  assign ack_tog = ack_tog_q;
`endif

endmodule

// File: tb/tb_cdc_toggle_rx.sv
// Directed bench for cdc_toggle_rx: expected delivered counts are queued when
// an accepted toggle is driven and checked when the handshake completes.
module tb_cdc_toggle_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tog_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_count;
  logic       overflow;
`ifdef CDC_TOGGLE_RX_ACK_EN
  logic       ack_tog;
  logic       model_ack = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] model_cnt = 8'd0;
  logic [7:0] exp_q[$];
  logic       vseen [0:4];

  cdc_toggle_rx #(.SYNC_STAGES(3), .PEND_W(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_count (evt_count),
    .overflow  (overflow),
`ifdef CDC_TOGGLE_RX_ACK_EN
    .ack_tog   (ack_tog),
`endif
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // toggle on a falling edge; push the count this event should produce if accepted
  task automatic send(input bit accepted);
    @(negedge clk);
    tog_in = ~tog_in;
    if (accepted) begin
      model_cnt = model_cnt + 8'd1;
      exp_q.push_back(model_cnt);
    end
  endtask

  // scoreboard: every completed handshake must match the next queued count
  always @(posedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      #1;
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("pop_count", 32'(evt_count), 32'(exp_q.pop_front()));
      end
`ifdef CDC_TOGGLE_RX_ACK_EN
      model_ack = ~model_ack;
      chk("ack_parity", 32'(ack_tog), 32'(model_ack));
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    // reset state
    #12;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(evt_count), 32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
`ifdef CDC_TOGGLE_RX_ACK_EN
    chk("rst_ack",   32'(ack_tog),   32'd0);
`endif
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single event with ready high: valid for one cycle, 3 edges after capture
    evt_ready = 1'b1;
    send(1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vseen[k] = evt_valid;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_valid_k%0d", k), 32'(vseen[k]), (k == 3) ? 32'd1 : 32'd0);
    end
    chk("t1_count", 32'(evt_count), 32'd1);

    // 2: three buffered events then back-to-back delivery
    @(negedge clk); evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1);
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("t2_pend", 32'(dut.pend_q), 32'd3);
    chk("t2_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t2_count_%0d", i), 32'(evt_count), 32'(2 + i));
    end
    chk("t2_valid_end", 32'(evt_valid), 32'd0);

    // 3: saturate pend, overflow sticky until clr_ovf
    @(negedge clk); evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(i < 3);
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("t3_pend_sat", 32'(dut.pend_q), 32'd3);
    chk("t3_ovf_set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    repeat (5) @(negedge clk);
    send(1'b1);
    repeat (8) @(negedge clk);
    chk("t3_ovf_stays0", 32'(overflow), 32'd0);
    chk("t3_count", 32'(evt_count), 32'd8);

    // 4: full with edge and pop together; then overflow set vs clr_ovf
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1);
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    send(1'b1);
    repeat (3) @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk); evt_ready = 1'b0;
    chk("t4_pend_hold", 32'(dut.pend_q), 32'd3);
    chk("t4_no_ovf", 32'(overflow), 32'd0);
    send(1'b0);
    repeat (3) @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("t4_set_wins", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // 5: async reset with pend=2, no spurious event afterwards
    evt_ready = 1'b1;
    @(negedge clk); evt_ready = 1'b0;
    chk("t5_pend2", 32'(dut.pend_q), 32'd2);
    #2;
    rst = 1'b1;
    tog_in = 1'b0;
    #1;
    chk("t5_async_valid", 32'(evt_valid), 32'd0);
    chk("t5_async_count", 32'(evt_count), 32'd0);
    chk("t5_async_pend",  32'(dut.pend_q), 32'd0);
    exp_q.delete();
    model_cnt = 8'd0;
`ifdef CDC_TOGGLE_RX_ACK_EN
    model_ack = 1'b0;
    chk("t5_async_ack", 32'(ack_tog), 32'd0);
`endif
    @(negedge clk); rst = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t5_quiet_%0d", i), 32'(evt_valid), 32'd0);
    end
    chk("t5_count0", 32'(evt_count), 32'd0);

    // 6: 256 delivered events wrap the counter
    for (int i = 0; i < 256; i++) begin
      send(1'b1);
      repeat (2) @(negedge clk);
      if (i == 7) begin
        repeat (6) @(negedge clk);
        chk("t6_count8", 32'(evt_count), 32'd8);
`ifdef CDC_TOGGLE_RX_ACK_EN
        chk("t6_ack8", 32'(ack_tog), 32'd0);
`endif
      end
    end
    repeat (8) @(negedge clk);
    chk("t6_wrap", 32'(evt_count), 32'd0);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_no_ovf", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
